// File: rtl/dma_xfer_sequencer_if.sv
// ============================================================================
// Module      : dma_xfer_sequencer_if
// Description : Peripheral request/acknowledge and main-RAM word bus of a
//               DMA transfer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_xfer_sequencer_if;
    logic        dreq;
    logic        dack;
    logic        memReq;
    logic [23:0] memAddr;
    logic        memAck;

    modport master (
        input  dreq,
        input  memAck,
        output dack,
        output memReq,
        output memAddr
    );

    modport slave (
        output dreq,
        output memAck,
        input  dack,
        input  memReq,
        input  memAddr
    );
endinterface

`default_nettype wire

// File: rtl/dma_xfer_sequencer.sv
// ============================================================================
// Module      : dma_xfer_sequencer
// Description : Per-channel DMA sequencer issuing word transfers at once or
//               block by block on peripheral request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_xfer_sequencer (
    input  wire logic                   i_clk,
    input  wire logic                   i_nrst,
    input  wire logic                   i_start,
    input  wire logic                   i_abort,
    input  wire logic [23:0]            i_cfgAddr,
    input  wire logic [15:0]            i_cfgBlkSize,
    input  wire logic [15:0]            i_cfgBlkCount,
    input  wire logic [1:0]             i_cfgSync,
    input  wire logic                   i_cfgStep,
    dma_xfer_sequencer_if.master        bus,
    output      logic                   o_busy,
    output      logic                   o_done,
    output      logic                   o_error,
    output      logic [23:0]            o_curAddr,
    output      logic [16:0]            o_remBlocks
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_REQ = 2'd1,
        S_XFER     = 2'd2,
        S_BLK_END  = 2'd3
    } state_t;

    state_t      r_state;
    logic [21:0] r_addr;
    logic [16:0] r_wordCnt;
    logic [16:0] r_blkCnt;
    logic [15:0] r_blkSize;
    logic        r_step;
    logic        r_memReq;
    logic        r_dack;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    // Zero-valued size/count fields encode 65536.
    logic [16:0] w_size;
    logic [16:0] w_count;
    logic [16:0] w_reload;
    logic        w_unused;

    assign w_size   = {(i_cfgBlkSize == 16'd0), i_cfgBlkSize};
    assign w_count  = {(i_cfgBlkCount == 16'd0), i_cfgBlkCount};
    assign w_reload = {(r_blkSize == 16'd0), r_blkSize};
    assign w_unused = ^i_cfgAddr[1:0];

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wordCnt <= '0;
            r_blkCnt  <= '0;
            r_blkSize <= '0;
            r_step    <= 1'b0;
            r_memReq  <= 1'b0;
            r_dack    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                // Abort outranks a coincident ack: the address is left as is.
                r_state  <= S_IDLE;
                r_memReq <= 1'b0;
                r_dack   <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            case (i_cfgSync)
                                2'd0: begin
                                    r_addr    <= i_cfgAddr[23:2];
                                    r_blkSize <= i_cfgBlkSize;
                                    r_wordCnt <= w_size;
                                    r_blkCnt  <= 17'd1;
                                    r_step    <= i_cfgStep;
                                    r_state   <= S_XFER;
                                    r_memReq  <= 1'b1;
                                    r_dack    <= 1'b0;
                                    r_busy    <= 1'b1;
                                end
                                2'd1: begin
                                    r_addr    <= i_cfgAddr[23:2];
                                    r_blkSize <= i_cfgBlkSize;
                                    r_wordCnt <= w_size;
                                    r_blkCnt  <= w_count;
                                    r_step    <= i_cfgStep;
                                    r_state   <= S_WAIT_REQ;
                                    r_busy    <= 1'b1;
                                end
                                default: r_error <= 1'b1;
                            endcase
                        end
                    end
                    S_WAIT_REQ: begin
                        // Only sync mode 1 ever reaches this state.
                        if (bus.dreq) begin
                            r_state  <= S_XFER;
                            r_memReq <= 1'b1;
                            r_dack   <= 1'b1;
                        end
                    end
                    S_XFER: begin
                        if (bus.memAck) begin
                            r_addr    <= r_step ? r_addr - 22'd1 : r_addr + 22'd1;
                            r_wordCnt <= r_wordCnt - 17'd1;
                            if (r_wordCnt == 17'd1) begin
                                r_state  <= S_BLK_END;
                                r_memReq <= 1'b0;
                                r_dack   <= 1'b0;
                                r_done   <= (r_blkCnt == 17'd1);
                            end
                        end
                    end
                    S_BLK_END: begin
                        r_blkCnt <= r_blkCnt - 17'd1;
                        if (r_blkCnt == 17'd1) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_wordCnt <= w_reload;
                            r_state   <= S_WAIT_REQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.memReq  = r_memReq;
    assign bus.memAddr = {r_addr, 2'b00};
    assign bus.dack    = r_dack;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_curAddr   = {r_addr, 2'b00};
    assign o_remBlocks = r_blkCnt;

endmodule

`default_nettype wire
